// File: rtl/fetch_if.sv
// Fetch-stage control/loader/output bundle between the core (master) and fetch_unit (slave).
interface fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_addr;
  logic            load_en;
  logic [XLEN-1:0] load_addr;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_fault;

  modport master (
    output stall, redirect, redirect_addr, load_en, load_addr, load_data,
    input  pc, instr, instr_pc, instr_valid, instr_fault
  );

  modport slave (
    input  stall, redirect, redirect_addr, load_en, load_addr, load_data,
    output pc, instr, instr_pc, instr_valid, instr_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, byte-addressed little-endian instruction memory,
// stall/redirect/flush, out-of-range fault and a word loader port.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     MEM_BYTES = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_WORD  = 32'h0000_0013
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave bus
);

  localparam int unsigned W     = XLEN / 8;
  localparam int unsigned OB    = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned XW    = XLEN + 1;

  logic [7:0]      mem [MEM_BYTES];
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            instr_valid_q;
  logic            instr_fault_q;

  logic [XLEN-1:0] load_base;
  logic [XLEN-1:0] redirect_base;
  logic            load_ok;
  logic            fetch_ok;
  logic [XLEN-1:0] rd_word;

  // Clear the low word-offset bits of a byte address.
  function automatic logic [XLEN-1:0] align_w(input logic [XLEN-1:0] a);
    align_w = (a >> OB) << OB;
  endfunction

  // Aligned addresses and range checks; the extra top bit keeps addr+W from wrapping.
  always_comb begin
    load_base     = align_w(bus.load_addr);
    redirect_base = align_w(bus.redirect_addr);
    load_ok       = (XW'({1'b0, load_base}) + XW'(W)) <= XW'(MEM_BYTES);
    fetch_ok      = (XW'({1'b0, pc_q}) + XW'(W)) <= XW'(MEM_BYTES);
  end

  // Little-endian word assembled from the bytes at pc (used only when fetch_ok).
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < W; i++) begin
      rd_word[8*i +: 8] = mem[IDX_W'(pc_q + XLEN'(i))];
    end
  end

  // PC / fetch registers and loader writes; memory itself is never reset,
  // and sharing the reset branch drops any load coincident with reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      instr_fault_q <= 1'b0;
    end else if (bus.load_en) begin
      if (load_ok) begin
        for (int unsigned i = 0; i < W; i++) begin
          mem[IDX_W'(load_base + XLEN'(i))] <= bus.load_data[8*i +: 8];
        end
      end
    end else if (bus.redirect) begin
      pc_q          <= redirect_base;
      instr_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      instr_pc_q    <= pc_q;
      instr_valid_q <= 1'b1;
      pc_q          <= pc_q + XLEN'(W);
      if (fetch_ok) begin
        instr_q       <= rd_word;
        instr_fault_q <= 1'b0;
      end else begin
        instr_q       <= XLEN'(NOP_WORD);
        instr_fault_q <= 1'b1;
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    bus.pc          = pc_q;
    bus.instr       = instr_q;
    bus.instr_pc    = instr_pc_q;
    bus.instr_valid = instr_valid_q;
    bus.instr_fault = instr_fault_q;
  end

endmodule
